// File: rtl/bodylength_checker_if.sv
// bodylength_checker_if
// Byte-stream bus between a FIX receive front end and bodylength_checker.
//   data_i      : stream byte (SOH = 0x01)
//   valid_i     : data_i valid this cycle, always accepted
//   sop_i       : first byte of a message, meaningful with valid_i
//   len_o       : parsed BodyLength (binary)
//   len_valid_o : len_o holds a completed parse
//   done_o      : one-cycle end-of-message / abort pulse
//   ok_o        : qualifies done_o, message passed
//   err_o       : error code, held until the next accepted sop_i
// master = stream source / result consumer, slave = the checker.
// LEN_WIDTH must match the checker instance's LEN_WIDTH.
`timescale 1ns/1ps
interface bodylength_checker_if #(
  parameter int LEN_WIDTH = 20
);
  logic [7:0]           data_i;
  logic                 valid_i;
  logic                 sop_i;
  logic [LEN_WIDTH-1:0] len_o;
  logic                 len_valid_o;
  logic                 done_o;
  logic                 ok_o;
  logic [2:0]           err_o;

  modport master (
    output data_i, valid_i, sop_i,
    input  len_o, len_valid_o, done_o, ok_o, err_o
  );

  modport slave (
    input  data_i, valid_i, sop_i,
    output len_o, len_valid_o, done_o, ok_o, err_o
  );
endinterface

// File: rtl/bodylength_checker.sv
// bodylength_checker
// Receive-side BodyLength (tag 9) checker for a FIX byte stream, one byte
// per cycle. Parses the ASCII tag 9 value, counts body bytes, checks that
// the body ends on SOH exactly at the declared length and that the "10="
// trailer follows, then reports length plus pass/fail verdict.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : bodylength_checker_if.slave (stream in, verdict out)
// Optional feature: define BODYLENGTH_CHECKSUM_EN to verify the 3-digit
// tag 10 checksum (sum of bytes from '8' through the body's final SOH,
// mod 256); mismatch or malformed value reports error 7.
// Error codes: 1 tag 9 header, 2 digit format, 3 length overflow,
// 4 body end not SOH, 5 trailer not "10=", 6 sop mid-message, 7 checksum.
//
// state  | meaning
// IDLE   | wait for valid sop
// BEGSTR | skip bytes through the first SOH
// T9     | expect '9'
// TEQ    | expect '='
// DIGITS | accumulate tag 9 value
// BODY   | count body bytes up to the declared length
// T1     | expect '1'
// T0     | expect '0'
// TEQ2   | expect '='
// TRAIL  | consume checksum value through SOH
// DONE   | message passed; a sop here is accepted back-to-back
`timescale 1ns/1ps
module bodylength_checker #(
  parameter int LEN_WIDTH  = 20,
  parameter int MAX_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  bodylength_checker_if.slave  bus
);
  typedef enum logic [3:0] {
    IDLE, BEGSTR, T9, TEQ, DIGITS, BODY, T1, T0, TEQ2, TRAIL, DONE
  } state_t;

  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam int XW = LEN_WIDTH + 4;

  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] acc, acc_n, cnt, cnt_n, len, len_n;
  logic [DW-1:0]        ndig, ndig_n;
  logic                 len_valid, len_valid_n, done, done_n, ok, ok_n;
  logic [2:0]           err, err_n;
`ifdef BODYLENGTH_CHECKSUM_EN
  logic [7:0]           sum, sum_n;
  logic [1:0]           tnd, tnd_n;
  logic [9:0]           tval, tval_n;
`endif

  logic [7:0]           b;
  logic                 is_digit, is_soh;
  logic [XW-1:0]        acc_x;
  logic [LEN_WIDTH-1:0] cnt_inc;
  logic                 fail, pass;
  logic [2:0]           fcode;

  assign b        = bus.data_i;
  assign is_digit = (b >= 8'h30) && (b <= 8'h39);
  assign is_soh   = (b == 8'h01);
  // Extra 4 bits hold len*10+9 for any len, so overflow is just the top bits.
  assign acc_x    = ({4'b0, acc} * XW'(10)) + XW'(b[3:0]);
  assign cnt_inc  = cnt + LEN_WIDTH'(1);

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    len_n       = len;
    ndig_n      = ndig;
    len_valid_n = len_valid;
    done_n      = 1'b0;
    ok_n        = ok;
    err_n       = err;
    fail        = 1'b0;
    pass        = 1'b0;
    fcode       = 3'd0;
`ifdef BODYLENGTH_CHECKSUM_EN
    sum_n       = sum;
    tnd_n       = tnd;
    tval_n      = tval;
`endif
    if (state == DONE) state_n = IDLE;
    if (bus.valid_i) begin
`ifdef BODYLENGTH_CHECKSUM_EN
      if (state inside {BEGSTR, T9, TEQ, DIGITS, BODY}) sum_n = sum + b;
`endif
      if (bus.sop_i && state != IDLE && state != DONE) begin
        fail  = 1'b1;
        fcode = 3'd6;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (bus.sop_i) begin
              state_n     = BEGSTR;
              len_valid_n = 1'b0;
              ok_n        = 1'b0;
              err_n       = 3'd0;
`ifdef BODYLENGTH_CHECKSUM_EN
              sum_n       = b;
`endif
            end
          end
          BEGSTR: if (is_soh) state_n = T9;
          T9: begin
            if (b == "9") state_n = TEQ;
            else begin fail = 1'b1; fcode = 3'd1; end
          end
          TEQ: begin
            if (b == "=") begin
              state_n = DIGITS;
              acc_n   = '0;
              ndig_n  = '0;
            end else begin fail = 1'b1; fcode = 3'd1; end
          end
          DIGITS: begin
            if (is_digit) begin
              if (ndig == DW'(MAX_DIGITS)) begin
                fail = 1'b1; fcode = 3'd2;
              end else if (acc_x[XW-1:LEN_WIDTH] != 4'd0) begin
                fail = 1'b1; fcode = 3'd3;
              end else begin
                acc_n  = acc_x[LEN_WIDTH-1:0];
                ndig_n = ndig + DW'(1);
              end
            end else if (is_soh && ndig != '0) begin
              len_n       = acc;
              len_valid_n = 1'b1;
              cnt_n       = '0;
              state_n     = (acc == '0) ? T1 : BODY;
            end else begin
              fail = 1'b1; fcode = 3'd2;
            end
          end
          BODY: begin
            cnt_n = cnt_inc;
            if (cnt_inc == len) begin
              if (is_soh) state_n = T1;
              else begin fail = 1'b1; fcode = 3'd4; end
            end
          end
          T1: begin
            if (b == "1") state_n = T0;
            else begin fail = 1'b1; fcode = 3'd5; end
          end
          T0: begin
            if (b == "0") state_n = TEQ2;
            else begin fail = 1'b1; fcode = 3'd5; end
          end
          TEQ2: begin
            if (b == "=") begin
              state_n = TRAIL;
`ifdef BODYLENGTH_CHECKSUM_EN
              tnd_n   = 2'd0;
              tval_n  = 10'd0;
`endif
            end else begin fail = 1'b1; fcode = 3'd5; end
          end
          TRAIL: begin
`ifdef BODYLENGTH_CHECKSUM_EN
            if (is_digit && tnd != 2'd3) begin
              tnd_n  = tnd + 2'd1;
              tval_n = (tval * 10'd10) + 10'(b[3:0]);
            end else if (is_soh && tnd == 2'd3 && tval == {2'b00, sum}) begin
              pass = 1'b1;
            end else begin
              fail = 1'b1; fcode = 3'd7;
            end
`else
            if (is_soh) pass = 1'b1;
`endif
          end
          default: state_n = IDLE;
        endcase
      end
    end
    if (pass) begin
      state_n = DONE;
      done_n  = 1'b1;
      ok_n    = 1'b1;
      err_n   = 3'd0;
    end
    if (fail) begin
      state_n = IDLE;
      done_n  = 1'b1;
      ok_n    = 1'b0;
      err_n   = fcode;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len       <= '0;
      ndig      <= '0;
      len_valid <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      err       <= 3'd0;
`ifdef BODYLENGTH_CHECKSUM_EN
      sum       <= 8'd0;
      tnd       <= 2'd0;
      tval      <= 10'd0;
`endif
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      len       <= len_n;
      ndig      <= ndig_n;
      len_valid <= len_valid_n;
      done      <= done_n;
      ok        <= ok_n;
      err       <= err_n;
`ifdef BODYLENGTH_CHECKSUM_EN
      sum       <= sum_n;
      tnd       <= tnd_n;
      tval      <= tval_n;
`endif
    end
  end

  assign bus.len_o       = len;
  assign bus.len_valid_o = len_valid;
  assign bus.done_o      = done;
  assign bus.ok_o        = ok;
  assign bus.err_o       = err;
endmodule

// File: tb/tb_bodylength_checker.sv
`timescale 1ns/1ps
module tb_bodylength_checker;
  localparam int LW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bodylength_checker_if #(.LEN_WIDTH(LW)) bus ();
  bodylength_checker_if #(.LEN_WIDTH(LW)) bus7 ();

  assign bus7.data_i  = bus.data_i;
  assign bus7.valid_i = bus.valid_i;
  assign bus7.sop_i   = bus.sop_i;

  bodylength_checker #(.LEN_WIDTH(LW), .MAX_DIGITS(6)) dut  (.clk(clk), .rst(rst), .bus(bus));
  bodylength_checker #(.LEN_WIDTH(LW), .MAX_DIGITS(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  typedef struct {
    int          cyc;
    bit          ok;
    logic [2:0]  err;
    bit          len_chk;
    logic [LW-1:0] len;
  } exp_t;

  exp_t sq[2][$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input bit ok, input logic [2:0] err, input bit lc, input int len);
    exp_t x;
    x.cyc = 0; x.ok = ok; x.err = err; x.len_chk = lc; x.len = LW'(len);
    return x;
  endfunction

  // Scoreboard monitor: every done pulse consumes one expected verdict.
  task automatic mon(input int k, input logic d, input logic o, input logic [2:0] e,
                     input logic [LW-1:0] l, input logic lv);
    exp_t x;
    if (d === 1'b1) begin
      if (sq[k].size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done dut%0d at cycle %0d", k, cyc);
      end else begin
        x = sq[k].pop_front();
        chk($sformatf("done_cycle dut%0d", k), cyc, x.cyc);
        chk($sformatf("ok dut%0d", k), {31'b0, o}, {31'b0, x.ok});
        chk($sformatf("err dut%0d", k), {29'b0, e}, {29'b0, x.err});
        if (x.len_chk) begin
          chk($sformatf("len dut%0d", k), 32'(l), 32'(x.len));
          chk($sformatf("len_valid dut%0d", k), {31'b0, lv}, 32'd1);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus.done_o, bus.ok_o, bus.err_o, bus.len_o, bus.len_valid_o);
      mon(1, bus7.done_o, bus7.ok_o, bus7.err_o, bus7.len_o, bus7.len_valid_o);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid_i = 1'b0; bus.sop_i = 1'b0; bus.data_i = 8'h00;
    end
  endtask

  // '|' stands for SOH. stop: index whose sampling yields done (-1: none),
  // bytes after it are not sent. sop_at: extra sop_i inside the message.
  task automatic send_msg(input string s, input int stop, input int sop_at, input bit gaps,
                          input bit chk_lv, input exp_t e6, input exp_t e7);
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) begin
          @(negedge clk);
          bus.valid_i = 1'b0;
          bus.sop_i   = 1'($urandom_range(1, 0));
          bus.data_i  = 8'($urandom_range(255, 0));
        end
      end
      @(negedge clk);
      if (chk_lv && i == 0) begin
        chk("len_valid_before_sop dut0", {31'b0, bus.len_valid_o}, 32'd1);
        chk("len_valid_before_sop dut1", {31'b0, bus7.len_valid_o}, 32'd1);
      end
      if (chk_lv && i == 1) begin
        chk("len_valid_after_sop dut0", {31'b0, bus.len_valid_o}, 32'd0);
        chk("len_valid_after_sop dut1", {31'b0, bus7.len_valid_o}, 32'd0);
      end
      c = s[i];
      if (c == 8'h7C) c = 8'h01;
      bus.data_i  = c;
      bus.valid_i = 1'b1;
      bus.sop_i   = (i == 0) || (i == sop_at);
      if (i == stop) begin
        e6.cyc = cyc + 1;
        e7.cyc = cyc + 1;
        sq[0].push_back(e6);
        sq[1].push_back(e7);
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " len dut0"}, 32'(bus.len_o), 0);
    chk({tag, " len_valid dut0"}, {31'b0, bus.len_valid_o}, 0);
    chk({tag, " done dut0"}, {31'b0, bus.done_o}, 0);
    chk({tag, " ok dut0"}, {31'b0, bus.ok_o}, 0);
    chk({tag, " err dut0"}, {29'b0, bus.err_o}, 0);
    chk({tag, " len dut1"}, 32'(bus7.len_o), 0);
    chk({tag, " len_valid dut1"}, {31'b0, bus7.len_valid_o}, 0);
    chk({tag, " err dut1"}, {29'b0, bus7.err_o}, 0);
  endtask

  localparam string M1 = "8=FIX.4.2|9=5|35=0|10=161|";

  initial begin
    bus.data_i = 8'h00; bus.valid_i = 1'b0; bus.sop_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    send_msg(M1, 25, -1, 0, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    idle(2);
    send_msg("8=FIX.4.2|9=4|35=0|10=161|", 17, -1, 0, 0, mk(0, 4, 1, 4), mk(0, 4, 1, 4));
    idle(2);
    send_msg("8=FIX.4.2|9=1234567|", 18, -1, 0, 0, mk(0, 2, 0, 0), mk(0, 3, 0, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=2A|", 13, -1, 0, 0, mk(0, 2, 0, 0), mk(0, 2, 0, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=9999999|", 18, -1, 0, 0, mk(0, 2, 0, 0), mk(0, 3, 0, 0));
    idle(1);
    send_msg("8=FIX.4.2|8=5|", 10, -1, 0, 0, mk(0, 1, 0, 0), mk(0, 1, 0, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=|", 12, -1, 0, 0, mk(0, 2, 0, 0), mk(0, 2, 0, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=0|11=", 15, -1, 0, 0, mk(0, 5, 1, 0), mk(0, 5, 1, 0));
    idle(1);
`ifdef BODYLENGTH_CHECKSUM_EN
    send_msg("8=FIX.4.2|9=0|10=xyz|", 17, -1, 0, 0, mk(0, 7, 1, 0), mk(0, 7, 1, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=5|35=0|10=160|", 25, -1, 0, 0, mk(0, 7, 1, 5), mk(0, 7, 1, 5));
`else
    send_msg("8=FIX.4.2|9=0|10=xyz|", 20, -1, 0, 0, mk(1, 0, 1, 0), mk(1, 0, 1, 0));
    idle(1);
    send_msg("8=FIX.4.2|9=5|35=0|10=160|", 25, -1, 0, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
`endif
    idle(2);
    send_msg(M1, 25, -1, 1, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    idle(2);
    send_msg(M1, 25, -1, 0, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    send_msg(M1, 25, -1, 0, 1, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    idle(2);
    send_msg(M1, 15, 15, 0, 0, mk(0, 6, 1, 5), mk(0, 6, 1, 5));
    idle(1);
    send_msg(M1, 25, -1, 0, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    idle(2);
    send_msg("8=FIX.4.2|9=12", -1, -1, 0, 0, mk(0, 0, 0, 0), mk(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    bus.valid_i = 1'b0; bus.sop_i = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    rst = 1'b0;
    idle(2);
    send_msg(M1, 25, -1, 0, 0, mk(1, 0, 1, 5), mk(1, 0, 1, 5));
    idle(6);

    for (int k = 0; k < 2; k++) begin
      while (sq[k].size() > 0) begin
        void'(sq[k].pop_front());
        n_cmp++; n_bad++;
        $display("FAIL missing_done dut%0d: got none expected a done pulse", k);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus expected finish before 200us");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/bodylength_checker.md
# bodylength_checker

Receive-side counterpart of the transmit BodyLength generator. Consumes an incoming FIX byte stream one byte per cycle. Parses the ASCII decimal value of tag 9 (BodyLength) into binary and counts the actual body bytes. Verifies that the body ends exactly where the declared length says, with the `10=` trailer following, and reports the parsed length with a pass/fail verdict per message to the downstream field parser.

## Interface
- `LEN_WIDTH`, 20, width of the binary body length.
- `MAX_DIGITS`, 6, maximum number of ASCII digits accepted in the tag 9 value.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data_i`  in  8  stream byte (SOH = 0x01).
- `valid_i`  in  1  `data_i` valid this cycle; no backpressure, a byte is always accepted.
- `sop_i`  in  1  qualifies the first byte (`8`) of a message; meaningful only with `valid_i`.
- `len_o`  out  LEN_WIDTH  parsed BodyLength, binary.
- `len_valid_o`  out  1  `len_o` holds a completed parse.
- `done_o`  out  1  one-cycle pulse at end of message or on abort.
- `ok_o`  out  1  qualifies `done_o`: message passed all checks.
- `err_o`  out  3  error code, held from `done_o` until next `sop_i`; 0 = none.

## Operation
- FSM states:
  - `IDLE`: wait for `valid_i & sop_i`.
  - `BEGSTR`: skip bytes through the first SOH.
  - `T9`: expect `9`.
  - `TEQ`: expect `=`.
  - `DIGITS`: accumulate value.
  - `BODY`: count bytes.
  - `T1`, `T0`, `TEQ2`: expect `1`, `0`, `=`.
  - `TRAIL`: consume through SOH.
  - `DONE`: back to `IDLE`.
- `DIGITS` accumulation: `len = len*10 + (byte-0x30)`. Leading zeros are accepted and count toward `MAX_DIGITS`. On SOH, latch `len_o`, set `len_valid_o`, then:
  - if `len == 0`, go to `T1`;
  - otherwise go to `BODY` with `cnt = 1` on the next byte.
- `BODY`: increment `cnt` per valid byte. When `cnt == len_o`, that byte must be SOH, then go to `T1`.
- Error codes; any error pulses `done_o` with `ok_o = 0` and returns to `IDLE`:
  - 1: byte after first SOH is not `9`, or not followed by `=`.
  - 2: non-digit in `DIGITS`, SOH with zero digits, or more than `MAX_DIGITS` digits.
  - 3: accumulated value exceeds 2^LEN_WIDTH−1.
  - 4: byte at position `len_o` of the body is not SOH.
  - 5: trailer is not `10=`.
  - 6: `sop_i` asserted while in any state other than `IDLE`/`DONE`. The aborting byte is not restarted; the next `sop_i` starts fresh.
- SOH inside the body before position `len_o` is legal field separation.
- Cycles with `valid_i = 0` hold all state and counters.

## Timing
- Reset values: `len_o = 0`, `len_valid_o = 0`, `done_o = 0`, `ok_o = 0`, `err_o = 0`, FSM in `IDLE`, `cnt = 0`.
- `len_o` and `len_valid_o` update on the clock edge that samples the SOH terminating tag 9. They are valid from the next cycle until the cycle after the next accepted `sop_i`, when `len_valid_o` clears.
- `done_o`/`ok_o`/`err_o` are registered. They assert the cycle after the sampled trailing SOH, or the cycle after the offending byte on an error.
- Back-to-back: `sop_i` may arrive in the cycle directly after the trailing SOH; it is accepted and `done_o` still pulses.
- `rst` mid-message forces `IDLE` immediately; the partial message is discarded and no `done_o` is produced.
- `cnt` is LEN_WIDTH bits and cannot wrap, because it stops at `len_o`.

## Configuration
- `BODYLENGTH_CHECKSUM_EN` defined:
  - An 8-bit sum accumulates every byte from `8` through the body's final SOH, modulo 256.
  - `TRAIL` requires exactly 3 ASCII digits before SOH and compares their value to the sum.
  - Mismatch or malformed value gives error 7.
- `BODYLENGTH_CHECKSUM_EN` undefined:
  - No sum is kept.
  - `TRAIL` skips any bytes up to SOH.
  - Code 7 is never produced.

## Test plan
- `8=FIX.4.2|9=5|35=0|10=161|` (`|` = SOH), one byte per cycle → `len_o = 5`, `len_valid_o = 1`; `done_o` pulses 1 cycle after final SOH with `ok_o = 1`, `err_o = 0` (checksum 161 also passes with the macro defined).
- Same message with `9=4` → `err_o = 4`, `ok_o = 0`, `done_o` 1 cycle after the `0` byte at body position 4.
- `9=1234567` with `MAX_DIGITS = 6` → `err_o = 2` on the 7th digit; `9=2A` → `err_o = 2`; `9=9999999` with `LEN_WIDTH = 20`, `MAX_DIGITS = 7` → `err_o = 3`.
- `9=0|10=xyz|` → `ok_o = 1` without checksum. With `BODYLENGTH_CHECKSUM_EN`, trailer `10=160|` on the first message → `err_o = 7`.
- Random `valid_i` gaps (50%) on the first message → identical outputs. Second message with `sop_i` on the cycle after the trailing SOH → both pass.
- `sop_i` asserted inside the body → `err_o = 6`. `rst` pulsed mid-`DIGITS` → all outputs 0, no `done_o`, next message passes.
